// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port req/ack arbiter sequencing accesses to a fixed-latency single-ported memory
// Define MEM_ARB_CPU_PRIORITY_EN for fixed port-0 priority; default build is round-robin.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic          gnt,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          lat_we;
  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef MEM_ARB_CPU_PRIORITY_EN
  assign pick = ~r0_req;
`else
  logic last;

  always_ff @(posedge CLK) begin
    if (RST)
      last <= 1'b1;
    else if (state == DONE)
      last <= gnt;
  end

  assign pick = (r0_req && r1_req) ? ~last : ~r0_req;
`endif

  assign sel_we    = pick ? r1_we    : r0_we;
  assign sel_addr  = pick ? r1_addr  : r0_addr;
  assign sel_wdata = pick ? r1_wdata : r0_wdata;

  // mem_addr/mem_wdata double as the latched request fields: they only load on a grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            gnt       <= pick;
            lat_we    <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            if (gnt) r1_ack <= 1'b1;
            else     r0_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= WAIT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (gnt) begin
              r1_rdata <= mem_rdata;
              r1_ack   <= 1'b1;
            end else begin
              r0_rdata <= mem_rdata;
              r0_ack   <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Expected grant order follows MEM_ARB_CPU_PRIORITY_EN when it is defined for the build.
module tb_mem_port_arbiter;
  localparam int RD_LAT = 3;

  logic        CLK, RST;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r1_ack, gnt, busy, mem_en, mem_we;
  logic [31:0] r0_rdata, r1_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .gnt(gnt), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // memory model: data appears exactly RD_LAT cycles after the mem_en cycle, poison otherwise
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [RD_LAT];
  logic        rd_vld  [RD_LAT];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= mem[mem_addr[7:0]];
    rd_vld[0]  <= mem_en && !mem_we;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_vld[i]  <= rd_vld[i-1];
    end
  end
  assign mem_rdata = rd_vld[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'hBAD0_BAD0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at #1 inside an IDLE cycle (cycle t); returns at #1 inside the ack cycle.
  task automatic access(input bit port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit glitch,
                        output int ack_n, output int en_n, output int we_n,
                        output int en_cnt, output int other_ack, output logic [31:0] addr_at_ack);
    ack_n = -1; en_n = -1; we_n = -1; en_cnt = 0; other_ack = 0; addr_at_ack = '0;
    if (!port) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
    else       begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
    for (int n = 1; n <= 40 && ack_n < 0; n++) begin
      @(posedge CLK); #1;
      if (glitch && n == 2) begin
        if (!port) r0_addr = 32'h10; else r1_addr = 32'h10;
      end
      if (mem_en) begin en_cnt++; en_n = n; end
      if (mem_en && mem_we) we_n = n;
      if (port ? r0_ack : r1_ack) other_ack++;
      if (port ? r1_ack : r0_ack) begin ack_n = n; addr_at_ack = mem_addr; end
    end
    r0_req = 0; r1_req = 0;
  endtask

  int a_n, e_n, w_n, e_c, o_a;
  logic [31:0] a_addr;
  int k, c0, c1, dual, t0, last_ack, exp_port, seen;

  initial begin
    RST = 1; pl_en = 0; pl_addr = 0; pl_data = 0;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_acks", {r0_ack, r1_ack}, 0);
    check_eq("rst_mem_en_we", {mem_en, mem_we}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_rdata", {r0_rdata, r1_rdata}, 0);
    pl_en = 1; pl_addr = 8'h40; pl_data = 32'hDEADBEEF;
    @(posedge CLK); #1;
    pl_en = 0; RST = 0;
    @(posedge CLK); #1;

    // single read
    access(0, 0, 32'h40, 0, 0, a_n, e_n, w_n, e_c, o_a, a_addr);
    check_eq("rd_ack_lat", a_n, RD_LAT + 2);
    check_eq("rd_en_cycle", e_n, 1);
    check_eq("rd_en_count", e_c, 1);
    check_eq("rd_no_we", w_n, -1);
    check_eq("rd_no_r1_ack", o_a, 0);
    check_eq("rd_rdata", r0_rdata, 32'hDEADBEEF);
    check_eq("rd_gnt", gnt, 0);
    @(posedge CLK); #1;
    check_eq("rd_ack_pulse", r0_ack, 0);
    check_eq("rd_idle_busy", busy, 0);

    // write from port 1, then read back on port 0
    access(1, 1, 32'h10, 32'h12345678, 0, a_n, e_n, w_n, e_c, o_a, a_addr);
    check_eq("wr_ack_lat", a_n, 2);
    check_eq("wr_we_cycle", w_n, 1);
    check_eq("wr_en_count", e_c, 1);
    check_eq("wr_gnt", gnt, 1);
    check_eq("wr_r1_rdata", r1_rdata, 0);
    @(posedge CLK); #1;
    access(0, 0, 32'h10, 0, 0, a_n, e_n, w_n, e_c, o_a, a_addr);
    check_eq("rb_ack_lat", a_n, RD_LAT + 2);
    check_eq("rb_r0_rdata", r0_rdata, 32'h12345678);
    check_eq("rb_r1_rdata", r1_rdata, 0);
    @(posedge CLK); #1;

    // address changes during WAIT are ignored
    access(0, 0, 32'h40, 0, 1, a_n, e_n, w_n, e_c, o_a, a_addr);
    check_eq("gl_ack_lat", a_n, RD_LAT + 2);
    check_eq("gl_rdata", r0_rdata, 32'hDEADBEEF);
    check_eq("gl_mem_addr", a_addr, 32'h40);
    @(posedge CLK); #1;

    // reset in the middle of WAIT
    r0_req = 1; r0_we = 0; r0_addr = 32'h40;
    repeat (2) begin @(posedge CLK); #1; end
    check_eq("mw_busy_pre", busy, 1);
    RST = 1;
    @(posedge CLK); #1;
    check_eq("mw_busy", busy, 0);
    check_eq("mw_mem_en", mem_en, 0);
    check_eq("mw_ack", r0_ack, 0);
    check_eq("mw_rdata", r0_rdata, 0);
    RST = 0; r0_req = 0;
    seen = 0;
    repeat (6) begin @(posedge CLK); #1; if (r0_ack) seen++; end
    check_eq("mw_no_late_ack", seen, 0);
    access(0, 0, 32'h40, 0, 0, a_n, e_n, w_n, e_c, o_a, a_addr);
    check_eq("mw_reissue_lat", a_n, RD_LAT + 2);
    check_eq("mw_reissue_rdata", r0_rdata, 32'hDEADBEEF);

    // contention from a fresh reset so port 0 wins the first tie
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    @(posedge CLK); #1;
    r0_req = 1; r0_we = 0; r0_addr = 32'h40;
    r1_req = 1; r1_we = 0; r1_addr = 32'h10;
    t0 = cyc; k = 0; c0 = 0; c1 = 0; dual = 0; last_ack = 0;
    for (int n = 0; n < 200 && k < 8; n++) begin
      @(posedge CLK); #1;
      if (r0_ack && r1_ack) dual++;
      if (r0_ack || r1_ack) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
        exp_port = 0;
`else
        exp_port = k % 2;
`endif
        check_eq($sformatf("ct_port%0d", k), r1_ack, exp_port);
        if (k == 0) check_eq("ct_first_lat", cyc - t0, RD_LAT + 2);
        else        check_eq($sformatf("ct_gap%0d", k), cyc - last_ack, RD_LAT + 3);
        last_ack = cyc;
        if (r1_ack) c1++; else c0++;
        k++;
      end
    end
    r0_req = 0;
    check_eq("ct_total", k, 8);
    check_eq("ct_dual", dual, 0);
`ifdef MEM_ARB_CPU_PRIORITY_EN
    check_eq("ct_r0_count", c0, 8);
    check_eq("ct_r1_count", c1, 0);
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(posedge CLK); #1;
      if (r1_ack) seen = n + 1;
    end
    check_eq("ct_r1_after_drop", seen, RD_LAT + 3);
`else
    check_eq("ct_r0_count", c0, 4);
    check_eq("ct_r1_count", c1, 4);
`endif
    r1_req = 0;
    check_eq("ct_r0_rdata", r0_rdata, 32'hDEADBEEF);
    check_eq("ct_r1_rdata", r1_rdata, 32'h12345678);
    repeat (3) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
